hwag_vr_filter: RTL and testbench

- Conditioning stage directly upstream of the hwag angle generator's vr_in.
- Synchronises the raw VR comparator output and applies a programmable digital glitch filter; the filter length comes from the ssram filter-value register (addr 0).
- Drives the filtered level into hwag vr_in.
- Also produces a selected-edge strobe and a tooth-period measurement for diagnostics and gap detection.

---
 rtl/hwag_pkg.sv | 13 +
 rtl/hwag_vr_sync.sv | 25 ++
 rtl/hwag_vr_filter.sv | 143 ++++++++++++++
 tb/tb_hwag_vr_filter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// hwag_pkg: shared widths and edge-select encoding for the hwag VR front end.
// Contents: HWAG_FILT_W, HWAG_PER_W, hwag_edge_t.
package hwag_pkg;

    localparam int HWAG_FILT_W = 16;
    localparam int HWAG_PER_W  = 24;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } hwag_edge_t;

endpackage

// File: rtl/hwag_vr_sync.sv
// hwag_vr_sync: generic 2-flop synchroniser for an asynchronous level.
// Ports: clk_i, rst_ni (sync, active-low), d_i (async in), q_o (synchronised out).
module hwag_vr_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/hwag_vr_filter.sv
// hwag_vr_filter: VR input synchroniser, glitch filter, edge strobe and tooth period.
// Ports: clk, rst (sync active-low), enable, filt_len, edge_sel, vr_in in;
//   vr_out, vr_edge, period, period_valid, period_ovf out (all registered).
// Build option: define HWAG_VR_PERIOD_EN to include the period counter logic;
//   without it period/period_valid/period_ovf are tied to 0.
module hwag_vr_filter
    import hwag_pkg::*;
#(
    parameter int FILT_W = HWAG_FILT_W,
    parameter int PER_W  = HWAG_PER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              edge_sel,
    input  logic              vr_in,
    output logic              vr_out,
    output logic              vr_edge,
    output logic [PER_W-1:0]  period,
    output logic              period_valid,
    output logic              period_ovf
);

    hwag_edge_t esel;
    logic       raw_s;

    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              edge_q, edge_d;
    logic              flip;
    logic              hit;

    assign esel = hwag_edge_t'(edge_sel);

    hwag_vr_sync u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (vr_in),
        .q_o    (raw_s)
    );

    // cnt counts clocks of disagreement; >= lets a shrinking filt_len
    // take effect at once and keeps cnt bounded by filt_len.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        flip  = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (raw_s == out_q) begin
            cnt_d = '0;
        end else if (cnt_q >= filt_len) begin
            out_d = raw_s;
            cnt_d = '0;
            flip  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        hit    = flip && (raw_s == (esel == EDGE_RISE));
        edge_d = hit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            edge_q <= edge_d;
        end
    end

    assign vr_out  = out_q;
    assign vr_edge = edge_q;

`ifdef HWAG_VR_PERIOD_EN
    localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};

    logic [PER_W-1:0] pcnt_q, pcnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             armed_q, armed_d;
    logic             pv_q, pv_d;
    logic             ovf_q, ovf_d;

    // The counter restarts at 1 on an edge so that period equals the
    // clock distance between consecutive selected edges.
    always_comb begin
        pcnt_d  = pcnt_q;
        per_d   = per_q;
        armed_d = armed_q;
        pv_d    = 1'b0;
        ovf_d   = ovf_q;
        if (!enable) begin
            pcnt_d  = '0;
            armed_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (pcnt_q != '1) begin
                pcnt_d = pcnt_q + 1'b1;
            end
            if (hit) begin
                if (armed_q) begin
                    per_d = pcnt_q;
                    pv_d  = 1'b1;
                    if (&pcnt_q) begin
                        ovf_d = 1'b1;
                    end
                end
                pcnt_d  = PER_ONE;
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt_q  <= '0;
            per_q   <= '0;
            armed_q <= 1'b0;
            pv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            per_q   <= per_d;
            armed_q <= armed_d;
            pv_q    <= pv_d;
            ovf_q   <= ovf_d;
        end
    end

    assign period       = per_q;
    assign period_valid = pv_q;
    assign period_ovf   = ovf_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
    assign period_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_hwag_vr_filter.sv
// tb_hwag_vr_filter: scoreboard bench for hwag_vr_filter (default and PER_W=8).
// Expected vr_out changes are queued at drive time and matched at negedge.
module tb_hwag_vr_filter;
    import hwag_pkg::*;

`ifdef HWAG_VR_PERIOD_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] filt_len = 16'd0;
    logic        edge_sel = 1'b0;
    logic        vr_in = 1'b0;

    logic        vr_out, vr_edge, period_valid, period_ovf;
    logic [23:0] period;
    logic        vr_out8, vr_edge8, period_valid8, period_ovf8;
    logic [7:0]  period8;

    hwag_vr_filter dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .filt_len     (filt_len),
        .edge_sel     (edge_sel),
        .vr_in        (vr_in),
        .vr_out       (vr_out),
        .vr_edge      (vr_edge),
        .period       (period),
        .period_valid (period_valid),
        .period_ovf   (period_ovf)
    );

    hwag_vr_filter #(.PER_W(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .filt_len     (filt_len),
        .edge_sel     (edge_sel),
        .vr_in        (vr_in),
        .vr_out       (vr_out8),
        .vr_edge      (vr_edge8),
        .period       (period8),
        .period_valid (period_valid8),
        .period_ovf   (period_ovf8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        bit lvl;
        bit edg;
        bit pv;
        int per;
        int per8;
        bit ovf8;
    } ev_t;

    ev_t  q[$];
    ev_t  mev;
    int   checks = 0;
    int   errors = 0;
    bit   m_armed = 1'b0;
    int   m_last = 0;
    bit   m_ovf8 = 1'b0;
    bit   mon_en = 1'b0;
    logic prev_out;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(int t, bit lvl);
        ev_t e;
        int  d;
        e.t    = t;
        e.lvl  = lvl;
        e.edg  = (lvl == (edge_sel == 1'b0));
        e.pv   = 1'b0;
        e.per  = 0;
        e.per8 = 0;
        if (e.edg) begin
            if (m_armed) begin
                d      = t - m_last;
                e.pv   = PER_EN;
                e.per  = d;
                e.per8 = (d > 255) ? 255 : d;
                if (d >= 255) m_ovf8 = 1'b1;
            end
            m_armed = 1'b1;
            m_last  = t;
        end
        e.ovf8 = PER_EN && m_ovf8;
        q.push_back(e);
    endtask

    task automatic drive(bit lvl);
        vr_in = lvl;
        push(cyc + 3 + int'(filt_len), lvl);
    endtask

    task automatic sq(int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1);
            tick(10);
            drive(1'b0);
            tick(10);
        end
    endtask

    task automatic en_pulse();
        enable  = 1'b0;
        m_armed = 1'b0;
        m_ovf8  = 1'b0;
        tick(1);
        enable  = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (vr_out8 !== vr_out) check("out8_eq", vr_out8, vr_out);
            if (vr_edge8 !== vr_edge) check("edge8_eq", vr_edge8, vr_edge);
            if (vr_out !== prev_out) begin
                if (q.size() == 0) begin
                    check("out_unexp", vr_out, prev_out);
                end else begin
                    mev = q.pop_front();
                    check("out_t", cyc, mev.t);
                    check("out_lvl", vr_out, mev.lvl);
                    check("edge", vr_edge, mev.edg);
                    check("pv", period_valid, mev.pv);
                    check("pv8", period_valid8, mev.pv);
                    if (mev.pv) begin
                        check("period", period, mev.per);
                        check("period8", period8, mev.per8);
                    end
                    check("ovf", period_ovf, 0);
                    check("ovf8", period_ovf8, mev.ovf8);
                end
            end else begin
                if (vr_edge) check("edge_spur", vr_edge, 0);
                if (period_valid) check("pv_spur", period_valid, 0);
                if (period_valid8) check("pv8_spur", period_valid8, 0);
            end
        end
        prev_out = vr_out;
    end

    int n0;

    initial begin
        // reset with vr_in high
        vr_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_outs", {vr_out, vr_edge, period_valid, period_ovf, period}, 0);
            check("rst_outs8", {vr_out8, vr_edge8, period_valid8, period_ovf8, period8}, 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rel_outs", {vr_out, vr_edge, period_valid, period_ovf, period}, 0);

        // square wave, rising edges
        vr_in = 1'b0;
        tick(4);
        prev_out = vr_out;
        mon_en   = 1'b1;
        enable   = 1'b1;
        filt_len = 16'd0;
        edge_sel = 1'b0;
        sq(4);
        tick(6);

        // glitch rejection
        filt_len = 16'd4;
        vr_in = 1'b1;
        tick(4);
        vr_in = 1'b0;
        tick(12);
        check("glitch", vr_out, 0);
        drive(1'b1);
        tick(5);
        drive(1'b0);
        tick(15);

        // falling edges
        filt_len = 16'd0;
        en_pulse();
        edge_sel = 1'b1;
        sq(4);
        tick(5);

        // long gap, saturation on the 8-bit instance
        edge_sel = 1'b0;
        en_pulse();
        drive(1'b1);
        tick(10);
        drive(1'b0);
        tick(290);
        drive(1'b1);
        tick(10);
        drive(1'b0);
        tick(10);
        sq(2);
        tick(5);
        check("ovf8_sticky", period_ovf8, PER_EN);
        enable  = 1'b0;
        m_armed = 1'b0;
        m_ovf8  = 1'b0;
        tick(1);
        enable  = 1'b1;
        check("ovf8_clr", period_ovf8, 0);
        check("per8_hold", period8, PER_EN ? 20 : 0);
        tick(3);

        // enable dropped mid-count
        filt_len = 16'd10;
        vr_in = 1'b1;
        tick(6);
        enable  = 1'b0;
        m_armed = 1'b0;
        m_ovf8  = 1'b0;
        tick(5);
        check("en_hold", vr_out, 0);
        enable = 1'b1;
        push(cyc + 11, 1'b1);
        tick(16);

        // reset mid-count
        vr_in = 1'b0;
        tick(4);
        mon_en = 1'b0;
        rst = 1'b0;
        tick(2);
        check("rst_mid", {vr_out, vr_edge, period_valid, period_ovf, period}, 0);
        check("rst_mid8", {vr_out8, vr_edge8, period_valid8, period_ovf8, period8}, 0);
        rst = 1'b1;
        q.delete();
        m_armed = 1'b0;
        m_ovf8  = 1'b0;
        tick(3);
        check("rst_after", vr_out, 0);
        prev_out = vr_out;
        mon_en = 1'b1;

        // shrink filt_len with cnt=5
        vr_in = 1'b1;
        n0 = cyc;
        tick(7);
        filt_len = 16'd2;
        push(n0 + 8, 1'b1);
        tick(5);

        for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
        check("drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
